// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache: direct-mapped, read-only instruction cache between the fetch stage
// and a 128-bit line memory.
//
// A hit returns the selected word combinationally in the same cycle as the
// PC lookup. A miss raises stall and refills one line through a
// mem_req/mem_ready handshake. flush invalidates every line. A flush that
// arrives during a refill is remembered, and the incoming line is dropped.
//
// Parameters
//   SETS        number of lines (power of two, >= 2)
//   DATA_WIDTH  instruction/address width (32; the line holds four words)
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   pc              fetch address, bits [1:0] ignored
//   instr           fetched instruction, NOP while stall=1
//   stall           freeze PC and fetch/decode register
//   flush           invalidate all lines (sampled on the clock edge)
//   mem_req         line-read request (registered state decode)
//   WriteEnable     tied low, the cache never writes memory
//   memory_address  line address of the outstanding refill, bits [3:0]=0
//   mem_readdata    returned line, word k in bits [32k+31:32k]
//   mem_ready       line valid this cycle, only honoured while mem_req=1
// ---------------------------------------------------------------------------
module icache #(
  parameter int SETS       = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  stall,
  input  logic                  flush,
  output logic                  mem_req,
  output logic                  WriteEnable,
  output logic [DATA_WIDTH-1:0] memory_address,
  input  logic [127:0]          mem_readdata,
  input  logic                  mem_ready
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int LINE_W = DATA_WIDTH - 4;
  localparam int TAG_W  = LINE_W - IDX_W;
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_REFILL = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  // Cache storage: valid bits are reset, tag/data arrays are not.
  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [127:0]      r_data [SETS];

  logic              r_flush_pending;
  // Line address of the refill in flight; the low four bits are always zero
  // and are not stored.
  logic [LINE_W-1:0] r_line_addr;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [1:0]        w_off;
  logic [IDX_W-1:0]  w_fill_idx;
  logic [TAG_W-1:0]  w_fill_tag;
  logic              w_hit;
  logic              w_fill_done;
  logic              w_fill_kill;
  logic [127:0]      w_line;
  logic [DATA_WIDTH-1:0] w_word;
  logic              w_unused;

  // The PC is byte addressed, but instructions are word aligned.
  assign w_unused = &{1'b0, pc[1:0]};

  assign w_off      = pc[3:2];
  assign w_idx      = pc[4 +: IDX_W];
  assign w_tag      = pc[DATA_WIDTH-1 -: TAG_W];
  // The refill writes into the latched set, not the current PC's set,
  // because the PC may move while the refill is outstanding.
  assign w_fill_idx = r_line_addr[IDX_W-1:0];
  assign w_fill_tag = r_line_addr[LINE_W-1 -: TAG_W];

  // A flush in the lookup cycle forces a miss, so the stale line is never
  // returned.
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !flush;

  assign w_fill_done = (r_state == S_REFILL) && mem_ready;
  // A flush that is pending, or that coincides with mem_ready, wins over the
  // fill.
  assign w_fill_kill = r_flush_pending || flush;

  assign w_line = r_data[w_idx];

  // Word select within the addressed line.
  always_comb begin
    w_word = '0;
    case (w_off)
      2'd0:    w_word = w_line[31:0];
      2'd1:    w_word = w_line[63:32];
      2'd2:    w_word = w_line[95:64];
      2'd3:    w_word = w_line[127:96];
      default: w_word = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic. A flush cycle in IDLE is a miss that does not
  // start a refill.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_hit && !flush) begin
          w_next_state = S_REFILL;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_REFILL: begin
        if (mem_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_REFILL;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: mem_req is a pure decode of the state register, so there is
  // no combinational path from mem_ready to mem_req.
  always_comb begin
    mem_req = 1'b0;
    stall   = 1'b1;
    case (r_state)
      S_IDLE: begin
        mem_req = 1'b0;
        stall   = !w_hit;
      end
      S_REFILL: begin
        mem_req = 1'b1;
        stall   = 1'b1;
      end
      default: begin
        mem_req = 1'b0;
        stall   = 1'b1;
      end
    endcase
  end

  // A NOP replaces the instruction while stalled, so decode never latches
  // stale data.
  always_comb begin
    if (stall) begin
      instr = NOP;
    end else begin
      instr = w_word;
    end
  end

  assign WriteEnable    = 1'b0;
  assign memory_address = {r_line_addr, 4'b0000};

  // Valid bits, pending flush, and the latched refill address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid         <= '0;
      r_flush_pending <= 1'b0;
      r_line_addr     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_valid <= '0;
          end else if (!w_hit) begin
            r_line_addr <= pc[DATA_WIDTH-1:4];
          end
        end
        S_REFILL: begin
          if (mem_ready) begin
            if (w_fill_kill) begin
              r_valid <= '0;
            end else begin
              r_valid[w_fill_idx] <= 1'b1;
            end
            r_flush_pending <= 1'b0;
          end else if (flush) begin
            r_flush_pending <= 1'b1;
          end
        end
        default: begin
          r_flush_pending <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays are written on refill completion. A killed fill
  // still writes, but its valid bit stays clear.
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem_readdata;
    end
  end

endmodule

// File: tb/tb_icache.sv
module tb_icache;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk;
  logic         rst;
  logic [31:0]  pc;
  logic [31:0]  instr;
  logic         stall;
  logic         flush;
  logic         mem_req;
  logic         WriteEnable;
  logic [31:0]  memory_address;
  logic [127:0] mem_readdata;
  logic         mem_ready;

  int n_cmp;
  int n_bad;

  icache #(.SETS(64), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .instr          (instr),
    .stall          (stall),
    .flush          (flush),
    .mem_req        (mem_req),
    .WriteEnable    (WriteEnable),
    .memory_address (memory_address),
    .mem_readdata   (mem_readdata),
    .mem_ready      (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: the word at byte address A holds A ^ 32'hA500_0000.
  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:4], 4'h0};
    return {b ^ 32'hA500_000C, b ^ 32'hA500_0008, b ^ 32'hA500_0004, b ^ 32'hA500_0000};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: called in the miss cycle C0; returns mem_ready in cycle
  // C<lat>, leaves the bench settled in cycle C<lat+1>.
  task automatic serve(input int lat);
    for (int k = 1; k <= lat; k++) begin
      next_cycle();
      mem_ready    = (k == lat);
      mem_readdata = line_of(memory_address);
    end
    next_cycle();
    mem_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = 32'h0; flush = 1'b0; mem_ready = 1'b0; mem_readdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (memory_address !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", memory_address); end
    n_cmp++; if (WriteEnable !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", WriteEnable); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL reset_stall: got %b want 1", stall); end
    n_cmp++; if (instr !== NOP) begin n_bad++; $display("FAIL reset_instr: got %h want %h", instr, NOP); end
    rst = 1'b0;
  endtask

  // Continues straight from reset release: C0 is the current cycle.
  task automatic test_cold_fetch();
    #1;
    n_cmp++; if (stall !== 1'b1 || mem_req !== 1'b0) begin n_bad++; $display("FAIL cold_c0: stall=%b mem_req=%b want 1/0", stall, mem_req); end
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      mem_ready    = (k == 3);
      mem_readdata = line_of(32'h0);
      #1;
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL cold_req c%0d: got %b want 1", k, mem_req); end
      n_cmp++; if (memory_address !== 32'h0) begin n_bad++; $display("FAIL cold_addr c%0d: got %h want 0", k, memory_address); end
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL cold_stall c%0d: got %b want 1", k, stall); end
    end
    next_cycle();
    mem_ready = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL cold_done_stall: got %b want 0", stall); end
    n_cmp++; if (instr !== 32'hA500_0000) begin n_bad++; $display("FAIL cold_instr: got %h want a5000000", instr); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL cold_req_drop: got %b want 0", mem_req); end
  endtask

  task automatic test_seq_hits();
    logic [31:0] exp_w [4];
    exp_w = '{32'hA500_0000, 32'hA500_0004, 32'hA500_0008, 32'hA500_000C};
    for (int k = 1; k < 4; k++) begin
      next_cycle();
      pc = 32'(k * 4);
      #1;
      n_cmp++; if (stall !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL seq_stall pc=%h: stall=%b req=%b want 0/0", pc, stall, mem_req); end
      n_cmp++; if (instr !== exp_w[k]) begin n_bad++; $display("FAIL seq_instr pc=%h: got %h want %h", pc, instr, exp_w[k]); end
    end
    // mem_ready while idle must be ignored.
    next_cycle();
    pc = 32'h4; mem_ready = 1'b1; mem_readdata = '1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL idle_ready_stall: got %b want 0", stall); end
    next_cycle();
    mem_ready = 1'b0;
    #1;
    n_cmp++; if (instr !== 32'hA500_0004 || mem_req !== 1'b0) begin n_bad++; $display("FAIL idle_ready_instr: got %h req=%b want a5000004/0", instr, mem_req); end
  endtask

  task automatic test_conflict();
    next_cycle();
    pc = 32'h400;
    #1;
    n_cmp++; if (stall !== 1'b1 || instr !== NOP) begin n_bad++; $display("FAIL conf_miss: stall=%b instr=%h want 1/nop", stall, instr); end
    serve(2);
    n_cmp++; if (stall !== 1'b0 || instr !== 32'hA500_0400) begin n_bad++; $display("FAIL conf_fill: stall=%b instr=%h want 0/a5000400", stall, instr); end
    next_cycle();
    pc = 32'h0;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL conf_evict: got stall=%b want 1", stall); end
    serve(1);
    n_cmp++; if (stall !== 1'b0 || instr !== 32'hA500_0000) begin n_bad++; $display("FAIL conf_refill: stall=%b instr=%h want 0/a5000000", stall, instr); end
  endtask

  task automatic test_flush();
    // Flush in IDLE.
    next_cycle();
    pc = 32'h0; flush = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1 || instr !== NOP) begin n_bad++; $display("FAIL flush_cycle: stall=%b instr=%h want 1/nop", stall, instr); end
    next_cycle();
    flush = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1 || mem_req !== 1'b0) begin n_bad++; $display("FAIL flush_after: stall=%b req=%b want 1/0", stall, mem_req); end
    serve(1);
    n_cmp++; if (stall !== 1'b0 || instr !== 32'hA500_0000) begin n_bad++; $display("FAIL flush_refill: stall=%b instr=%h want 0/a5000000", stall, instr); end
    // Flush during REFILL, mem_ready the next cycle.
    next_cycle();
    pc = 32'h10;
    #1;
    next_cycle();
    flush = 1'b1;
    #1;
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL flush_ref_req: got %b want 1", mem_req); end
    next_cycle();
    flush = 1'b0; mem_ready = 1'b1; mem_readdata = line_of(32'h10);
    #1;
    next_cycle();
    mem_ready = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1 || mem_req !== 1'b0) begin n_bad++; $display("FAIL flush_ref_inval: stall=%b req=%b want 1/0", stall, mem_req); end
    serve(1);
    n_cmp++; if (stall !== 1'b0 || instr !== 32'hA500_0010) begin n_bad++; $display("FAIL flush_ref_refill: stall=%b instr=%h want 0/a5000010", stall, instr); end
    // Line 0x0 was cleared by the pending flush.
    next_cycle();
    pc = 32'h0;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL flush_ref_all: got stall=%b want 1", stall); end
    serve(1);
    // Flush and mem_ready in the same REFILL cycle.
    next_cycle();
    pc = 32'h30;
    #1;
    next_cycle();
    flush = 1'b1; mem_ready = 1'b1; mem_readdata = line_of(32'h30);
    #1;
    next_cycle();
    flush = 1'b0; mem_ready = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1 || mem_req !== 1'b0) begin n_bad++; $display("FAIL flush_same: stall=%b req=%b want 1/0", stall, mem_req); end
    serve(1);
    n_cmp++; if (stall !== 1'b0 || instr !== 32'hA500_0030) begin n_bad++; $display("FAIL flush_same_refill: stall=%b instr=%h want 0/a5000030", stall, instr); end
  endtask

  task automatic test_reset_mid_refill();
    next_cycle();
    pc = 32'h50;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rstmid_miss: got stall=%b want 1", stall); end
    next_cycle();
    next_cycle();
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_req: got %b want 1", mem_req); end
    rst = 1'b1;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || memory_address !== 32'h0) begin n_bad++; $display("FAIL rstmid_async: req=%b addr=%h want 0/0", mem_req, memory_address); end
    next_cycle();
    rst = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1 || mem_req !== 1'b0) begin n_bad++; $display("FAIL rstmid_release: stall=%b req=%b want 1/0", stall, mem_req); end
    next_cycle();
    n_cmp++; if (mem_req !== 1'b1 || memory_address !== 32'h50) begin n_bad++; $display("FAIL rstmid_rereq: req=%b addr=%h want 1/50", mem_req, memory_address); end
    mem_ready = 1'b1; mem_readdata = line_of(32'h50);
    next_cycle();
    mem_ready = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0 || instr !== 32'hA500_0050) begin n_bad++; $display("FAIL rstmid_fill: stall=%b instr=%h want 0/a5000050", stall, instr); end
  endtask

  task automatic test_pc_change();
    next_cycle();
    pc = 32'h20;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL pcchg_miss: got stall=%b want 1", stall); end
    next_cycle();
    pc = 32'h100;
    #1;
    n_cmp++; if (memory_address !== 32'h20 || mem_req !== 1'b1) begin n_bad++; $display("FAIL pcchg_addr: addr=%h req=%b want 20/1", memory_address, mem_req); end
    next_cycle();
    mem_ready = 1'b1; mem_readdata = line_of(memory_address);
    #1;
    n_cmp++; if (memory_address !== 32'h20) begin n_bad++; $display("FAIL pcchg_addr_hold: got %h want 20", memory_address); end
    next_cycle();
    mem_ready = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1 || mem_req !== 1'b0) begin n_bad++; $display("FAIL pcchg_newmiss: stall=%b req=%b want 1/0", stall, mem_req); end
    next_cycle();
    n_cmp++; if (mem_req !== 1'b1 || memory_address !== 32'h100) begin n_bad++; $display("FAIL pcchg_newreq: req=%b addr=%h want 1/100", mem_req, memory_address); end
    mem_ready = 1'b1; mem_readdata = line_of(32'h100);
    next_cycle();
    mem_ready = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0 || instr !== 32'hA500_0100) begin n_bad++; $display("FAIL pcchg_fill: stall=%b instr=%h want 0/a5000100", stall, instr); end
    next_cycle();
    pc = 32'h24;
    #1;
    n_cmp++; if (stall !== 1'b0 || instr !== 32'hA500_0024) begin n_bad++; $display("FAIL pcchg_old: stall=%b instr=%h want 0/a5000024", stall, instr); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_cold_fetch();
    test_seq_hits();
    test_conflict();
    test_flush();
    test_reset_mid_refill();
    test_pc_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the fetch stage and a 128-bit line memory. It uses the same handshake as the data-side cache's backing store (`mem_req`/`mem_ready`, 128-bit lines).
- Hits return the instruction in the same cycle as the PC lookup.
- Misses raise `stall`, which is ORed into StallF/StallD, while one line is refilled.
- A `flush` input invalidates every line, for `fence.i` or after reloading program memory.

## Interface
- `SETS`, 64: number of lines; power of two, ≥2.
- `DATA_WIDTH`, 32: instruction and address width.
- `clk` in 1: clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `pc` in 32: fetch address; bits [1:0] are ignored.
- `instr` out 32: fetched instruction; valid when `stall`=0.
- `stall` out 1: freeze the PC and the fetch/decode register.
- `flush` in 1: invalidate all lines; level-sampled on the clock edge.
- `mem_req` out 1: line-read request to memory.
- `WriteEnable` out 1: constant 0; the block never writes.
- `memory_address` out 32: line address, with bits [3:0]=0.
- `mem_readdata` in 128: returned line; word k is in bits [32k+31:32k].
- `mem_ready` in 1: line valid this cycle; meaningful only while `mem_req`=1.

## Operation
- Address split:
  - offset = `pc[3:2]` selects the word.
  - index = `pc[3+log2(SETS):4]`.
  - tag = the remaining upper bits.
- Storage per set: a valid bit, a tag, and a 128-bit data line. Array reads are combinational; writes are synchronous.
- FSM states:
  - IDLE: lookup. A hit is `valid[index]` && tag match && `flush`=0. On a hit, `instr` = the selected word and `stall`=0.
    - On a miss: `stall`=1 combinationally in the same cycle. The line address `{pc[31:4],4'b0}` is latched into `memory_address`, and the next state is REFILL.
  - REFILL: `mem_req`=1; `memory_address` stays stable; `stall`=1.
    - On `mem_ready`=1: write the tag and line into `index`, set valid unless a flush is pending, clear the pending flag, and move to IDLE.
- `flush` in IDLE clears all valid bits at the edge. That cycle is treated as a miss: `stall`=1, but no refill starts and the next state stays IDLE.
- `flush` in REFILL sets `flush_pending`. At completion, all valids are cleared and the filled line is left invalid.
- While `stall`=1, `instr` = 32'h0000_0013 (NOP), so the decode register never sees stale data.
- A `pc` change during REFILL does not alter the request. Refill completes for the latched address; the lookup resumes with the current `pc` in IDLE.
- Only one refill is outstanding at a time. A `mem_ready` seen while `mem_req`=0 is ignored.

## Timing
- Reset (async, takes effect immediately):
  - state = IDLE; all valid bits = 0; `flush_pending` = 0.
  - `mem_req` = 0; `memory_address` = 0; `WriteEnable` = 0.
- Outputs during reset: `stall` follows the lookup, which misses, so `stall`=1 and `instr`=NOP whenever `rst` is deasserted with a cold cache.
- Hit latency: 0 cycles; `instr` is combinational from `pc`.
- Miss penalty: miss cycle C0 is in IDLE; `mem_req` is first high in C1. If `mem_ready` arrives in cycle Cn, the line is written at the end of Cn. The next lookup, in Cn+1, hits with `stall`=0. Total stall = n+1 cycles.
- `mem_req` is a registered state decode with no combinational path from `mem_ready`. It deasserts in the cycle after `mem_ready`.
- Reset asserted mid-REFILL: `mem_req` drops asynchronously. Memory must tolerate an abandoned request; the returned data is discarded.
- `flush` and `mem_ready` in the same REFILL cycle: the flush wins and the line is not validated.
- Aliasing: two PCs with the same index and different tags evict each other. Alternating fetches between them miss every time, with no corruption.

## Test plan
- Cold fetch, `pc`=0x0, memory latency 3:
  - `stall`=1 for 4 cycles; `mem_req` high for 3 cycles with `memory_address`=0x0.
  - Then `instr` = word0 of the line, with `stall`=0.
- Sequential hits: after filling 0x0, fetch `pc`=0x4, 0x8, 0xC → words 1–3 in consecutive cycles, `stall`=0 throughout, no `mem_req`.
- Conflict, SETS=64: fetch 0x0000, then 0x0400 (same index 0, different tag) → miss, refill, and the correct word; refetching 0x0000 misses again.
- Flush:
  - After 0x0 is cached, pulse `flush` one cycle → the next fetch of 0x0 misses.
  - Flush during REFILL with `mem_ready` the next cycle → the line is not valid and the refetch misses.
- Reset mid-REFILL (assert `rst` two cycles into a miss) → `mem_req`=0 immediately; after release, the fetch of the same PC re-requests.
- `pc` changes from 0x20 to 0x100 during REFILL → `memory_address` stays 0x20; after fill, a miss on 0x100 starts a new refill.
